// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store front end for a 256x32 word RAM.
// Sub-word stores are read-modify-write; sub-word loads are lane-extracted
// and sign/zero extended. The RAM read data updates on the falling edge, so
// a single RD cycle is enough to capture it at the following rising edge.
// Optional feature: define MAU_MISALIGN_TRAP_EN to trap misaligned requests
// (err+done pulse, no RAM access) instead of silently aligning them down.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           rdata,
    output logic                  ram_w_enable,
    output logic [ADDR_WIDTH-3:0] ram_addr,
    output logic [31:0]           ram_data_out,
    input  logic [31:0]           ram_data_in
);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

    state_t state, state_d;

    // Request fields captured at acceptance; later input changes are ignored.
    logic        we_q, sign_q;
    logic [1:0]  size_q, off_q;
    logic [15:0] wdata_q;  // word stores use wdata directly, so only the low half is kept

    logic        is_word, is_half, trap, accept;
    logic [1:0]  off_in;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val, merged;

    // Next values of the registered outputs
    logic                  busy_d, done_d, err_d, wen_d;
    logic [31:0]           rdata_d, wdo_d;
    logic [ADDR_WIDTH-3:0] raddr_d;

    assign is_word = size[1];  // 10 and 11 both mean word
    assign is_half = (size == 2'b01);

`ifdef MAU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    assign trap       = misaligned;
    assign off_in     = addr[1:0];
`else
    // Misaligned accesses are aligned down to their natural boundary.
    assign trap   = 1'b0;
    assign off_in = is_word ? 2'b00 : (is_half ? {addr[1], 1'b0} : addr[1:0]);
`endif

    assign accept = (state == IDLE) && req && !trap;

    // Lane extraction and sign/zero extension of the captured RAM word
    always_comb begin
        lane_b = ram_data_in[{off_q, 3'b000} +: 8];
        lane_h = off_q[1] ? ram_data_in[31:16] : ram_data_in[15:0];
        case (size_q)
            2'b00:   load_val = {{24{sign_q & lane_b[7]}}, lane_b};
            2'b01:   load_val = {{16{sign_q & lane_h[15]}}, lane_h};
            default: load_val = ram_data_in;
        endcase
    end

    // Merge the store data into the word read back during RD
    always_comb begin
        merged = ram_data_in;
        if (size_q == 2'b00)
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        else if (off_q[1])
            merged[31:16] = wdata_q;
        else
            merged[15:0] = wdata_q;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = (we && is_word) ? WR : RD;
            RD:      state_d = we_q ? WR : IDLE;
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        busy_d  = busy;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wen_d   = 1'b0;
        rdata_d = rdata;
        wdo_d   = ram_data_out;
        raddr_d = ram_addr;
        case (state)
            IDLE: begin
                if (req && trap) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end else if (req) begin
                    busy_d  = 1'b1;
                    raddr_d = addr[ADDR_WIDTH-1:2];
                    if (we && is_word) begin
                        wdo_d = wdata;
                        wen_d = 1'b1;
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    wdo_d = merged;
                    wen_d = 1'b1;
                end else begin
                    rdata_d = load_val;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            WR: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: busy_d = 1'b0;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            ram_w_enable <= 1'b0;
            rdata        <= '0;
            ram_addr     <= '0;
            ram_data_out <= '0;
        end else begin
            busy         <= busy_d;
            done         <= done_d;
            err          <= err_d;
            ram_w_enable <= wen_d;
            rdata        <= rdata_d;
            ram_addr     <= raddr_d;
            ram_data_out <= wdo_d;
        end
    end

    // Capture request fields on acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= we;
            sign_q  <= sign_ext;
            size_q  <= size;
            off_q   <= off_in;
            wdata_q <= wdata[15:0];
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: RAM model with falling-edge read data, directed
// accesses whose expected results are queued at issue time and checked by a
// monitor when done pulses.
module tb_mem_access_unit;

    logic        clk, reset, req, we, sign_ext;
    logic [1:0]  size;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        busy, done, err, ram_w_enable;
    logic [31:0] rdata, ram_data_out, ram_data_in;
    logic [7:0]  ram_addr;

    mem_access_unit #(.ADDR_WIDTH(10)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
        .done(done), .err(err), .rdata(rdata), .ram_w_enable(ram_w_enable),
        .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_data_in(ram_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: write on rising edge, registered read data on falling edge
    logic [31:0] mem [256] = '{default: 32'h0};
    int cyc = 0;
    int wen_count = 0;
    always @(posedge clk) begin
        cyc++;
        if (ram_w_enable) begin
            mem[ram_addr] <= ram_data_out;
            wen_count++;
        end
    end
    always @(negedge clk) ram_data_in <= mem[ram_addr];

    typedef struct {
        int          id;
        bit          is_store;  // store: check RAM word; load: check rdata
        int          idx;
        logic [31:0] val;
        int          lat;       // rising edges from acceptance to done
        bit          err;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   done_cyc[$];
    int   errors = 0, checks = 0, next_id = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: pop and compare on every completion
    always @(negedge clk) begin
        if (!reset && done) begin
            done_cyc.push_back(cyc);
            if (q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk($sformatf("acc%0d_latency", e.id), cyc - e.acc, e.lat);
                chk($sformatf("acc%0d_err", e.id), {31'd0, err}, {31'd0, e.err});
                if (e.is_store) chk($sformatf("acc%0d_ram", e.id), mem[e.idx], e.val);
                else            chk($sformatf("acc%0d_rdata", e.id), rdata, e.val);
            end
        end
    end

    // Drive one request; returns #1 after the accepting edge
    task automatic issue(input bit w, input logic [1:0] sz, input bit sx,
                         input logic [9:0] a, input logic [31:0] wd, input bit keep,
                         input bit push, input bit is_st, input int idx,
                         input logic [31:0] ev, input int lat, input bit ee);
        int n = 0;
        exp_t e;
        @(negedge clk);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            chk("accept_timeout", 32'd1, 32'd0);
            req = 1'b0;
            return;
        end
        if (push) begin
            e.id = next_id; e.is_store = is_st; e.idx = idx; e.val = ev;
            e.lat = lat; e.err = ee; e.acc = cyc + 1;
            q.push_back(e);
            next_id++;
        end
        @(posedge clk);
        #1;
        if (!keep) req = 1'b0;
    endtask

    task automatic st(input logic [9:0] a, input logic [1:0] sz, input logic [31:0] wd,
                      input logic [31:0] ev, input int lat, input bit keep);
        issue(1'b1, sz, 1'b0, a, wd, keep, 1'b1, 1'b1, int'(a[9:2]), ev, lat, 1'b0);
    endtask

    task automatic ld(input logic [9:0] a, input logic [1:0] sz, input bit sx,
                      input logic [31:0] ev, input int lat, input bit ee);
        issue(1'b0, sz, sx, a, 32'h0, 1'b0, 1'b1, 1'b0, 0, ev, lat, ee);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, nd;
        reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        // Reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_wen", {31'd0, ram_w_enable}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
        chk("rst_ram_data_out", ram_data_out, 32'd0);
        reset = 1'b0;

        // Reset in RD of a byte read-modify-write
        st(10'h014, 2'b10, 32'h55667788, 32'h55667788, 1, 1'b0);
        drain();
        wb = wen_count;
        issue(1'b1, 2'b00, 1'b0, 10'h014, 32'h00000099, 1'b0, 1'b0, 1'b1, 5, 0, 0, 1'b0);
        chk("midop_in_rd_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midop_busy", {31'd0, busy}, 32'd0);
        chk("midop_wen", {31'd0, ram_w_enable}, 32'd0);
        chk("midop_done", {31'd0, done}, 32'd0);
        chk("midop_ram_data_out", ram_data_out, 32'd0);
        repeat (2) @(negedge clk);
        chk("midop_wen_count", wen_count - wb, 32'd0);
        chk("midop_ram_word", mem[5], 32'h55667788);
        reset = 1'b0;

        // Word store then word load
        st(10'h010, 2'b10, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1'b0);
        ld(10'h010, 2'b10, 1'b0, 32'hDEADBEEF, 1, 1'b0);
        drain();

        // Sub-word loads, signed and unsigned
        st(10'h010, 2'b10, 32'h80FF7F01, 32'h80FF7F01, 1, 1'b0);
        ld(10'h013, 2'b00, 1'b1, 32'hFFFFFF80, 1, 1'b0);
        ld(10'h012, 2'b01, 1'b0, 32'h000080FF, 1, 1'b0);
        ld(10'h010, 2'b00, 1'b1, 32'h00000001, 1, 1'b0);
        ld(10'h011, 2'b00, 1'b0, 32'h0000007F, 1, 1'b0);
        ld(10'h012, 2'b01, 1'b1, 32'hFFFF80FF, 1, 1'b0);
        ld(10'h012, 2'b00, 1'b1, 32'hFFFFFFFF, 1, 1'b0);
        drain();

        // Read-modify-write stores; stores leave rdata alone
        st(10'h010, 2'b10, 32'h11223344, 32'h11223344, 1, 1'b0);
        drain();
        wb = wen_count;
        st(10'h011, 2'b00, 32'hFFFFFFAB, 32'h1122AB44, 2, 1'b0);
        drain();
        chk("rmw_wen_cycles", wen_count - wb, 32'd1);
        st(10'h012, 2'b01, 32'h1234CAFE, 32'hCAFEAB44, 2, 1'b0);
        drain();
        chk("store_keeps_rdata", rdata, 32'hFFFFFFFF);

        // Back-to-back with req held high through the first access
        wb = wen_count;
        nd = done_cyc.size();
        st(10'h020, 2'b10, 32'h0BADF00D, 32'h0BADF00D, 1, 1'b1);
        ld(10'h020, 2'b10, 1'b0, 32'h0BADF00D, 1, 1'b0);
        drain();
        repeat (3) @(negedge clk);
        chk("b2b_wen_count", wen_count - wb, 32'd1);
        chk("b2b_done_count", done_cyc.size() - nd, 32'd2);
        if (done_cyc.size() >= nd + 2)
            chk("b2b_done_spacing", done_cyc[nd+1] - done_cyc[nd], 32'd2);

        // Misaligned accesses
        wb = wen_count;
`ifdef MAU_MISALIGN_TRAP_EN
        ld(10'h011, 2'b01, 1'b0, 32'h0BADF00D, 0, 1'b1);
        chk("mis_busy_low", {31'd0, busy}, 32'd0);
        drain();
        ld(10'h013, 2'b10, 1'b0, 32'h0BADF00D, 0, 1'b1);
        chk("mis_word_busy_low", {31'd0, busy}, 32'd0);
        drain();
`else
        ld(10'h011, 2'b01, 1'b0, 32'h0000AB44, 1, 1'b0);
        chk("mis_busy_high", {31'd0, busy}, 32'd1);
        drain();
        ld(10'h013, 2'b10, 1'b0, 32'hCAFEAB44, 1, 1'b0);
        drain();
`endif
        chk("mis_no_write", wen_count - wb, 32'd0);

        repeat (3) @(negedge clk);
        chk("final_queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
